// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_stall,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_valid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester holds *_req (and its operands) until its *_valid pulse;
  // the memory side sees o_mem_req held with stable operands until one i_mem_ack pulse.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nx;
  logic   resp_dm, resp_dm_nx;
  logic   grant_if, grant_dm;
  logic   busy_ack;

`ifdef MEM_ARB_RR_EN
  logic ptr_dm;

  // Pointer names the requester that wins the next tie; it moves away from every grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_dm <= 1'b1;
    end else if (grant_dm) begin
      ptr_dm <= 1'b0;
    end else if (grant_if) begin
      ptr_dm <= 1'b1;
    end
  end

  assign grant_dm = (state == IDLE) && i_dm_req && (!i_if_req || ptr_dm);
`else
  assign grant_dm = (state == IDLE) && i_dm_req;
`endif

  assign grant_if = (state == IDLE) && i_if_req && !grant_dm;
  assign busy_ack = ((state == IF_BUSY) || (state == DM_BUSY)) && i_mem_ack;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      resp_dm <= 1'b0;
    end else begin
      state   <= state_nx;
      resp_dm <= resp_dm_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    resp_dm_nx = resp_dm;
    o_if_valid = 1'b0;
    o_dm_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_nx = DM_BUSY;
        end else if (grant_if) begin
          state_nx = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (i_mem_ack) begin
          state_nx   = RESP;
          resp_dm_nx = 1'b0;
        end
      end
      DM_BUSY: begin
        if (i_mem_ack) begin
          state_nx   = RESP;
          resp_dm_nx = 1'b1;
        end
      end
      RESP: begin
        state_nx   = IDLE;
        o_if_valid = !resp_dm;
        o_dm_valid = resp_dm;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory operands are latched at grant so they stay frozen for the whole access.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
    end else if (grant_dm) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= i_dm_we;
      o_mem_addr  <= i_dm_addr;
      o_mem_wdata <= i_dm_wdata;
    end else if (grant_if) begin
      o_mem_req   <= 1'b1;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= i_if_addr;
      o_mem_wdata <= '0;
    end else if (busy_ack) begin
      o_mem_req <= 1'b0;
      if (state == IF_BUSY) begin
        o_if_rdata <= i_mem_rdata;
      end else if (!o_mem_we) begin
        o_dm_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_if_stall = i_if_req && !o_if_valid;
  assign dbg_state  = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (request order by policy, word memory, latency by arithmetic).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        o_if_stall;
  logic        i_dm_req = 1'b0;
  logic        i_dm_we = 1'b0;
  logic [31:0] i_dm_addr = '0;
  logic [31:0] i_dm_wdata = '0;
  logic        o_dm_valid;
  logic [31:0] o_dm_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ack;
  logic [1:0]  dbg_state;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
    .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
    .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          stable;
  } acc_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  acc_t        acc_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  bit          auto_ack = 1'b1;
  bit          rand_lat = 1'b0;
  bit          spur_ack = 1'b0;
  int          ack_lat = 1;
`ifdef MEM_ARB_RR_EN
  bit          rr_mode = 1'b1;
`else
  bit          rr_mode = 1'b0;
`endif
  bit          m_ptr_dm = 1'b1;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_dm_rdata = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Tie winner: data always, or the round-robin pointer's choice.
  function automatic bit model_dm_first();
    return rr_mode ? m_ptr_dm : 1'b1;
  endfunction

  task automatic model_reset();
    m_ptr_dm   = 1'b1;
    m_if_rdata = '0;
    m_dm_rdata = '0;
  endtask

  // ---------------- memory responder ----------------
  initial begin : responder
    bit   busy;
    int   cnt;
    acc_t cur;
    busy = 1'b0;
    cnt = 0;
    cur = '{we: 1'b0, addr: '0, wdata: '0, lat: 1, stable: 1'b1};
    i_mem_ack = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (i_mem_ack) begin
        i_mem_ack = 1'b0;
        busy = 1'b0;
      end else if (spur_ack) begin
        spur_ack = 1'b0;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hBAD0_0BAD;
      end else begin
        if (busy) begin
          cnt++;
          if (o_mem_req !== 1'b1 || o_mem_we !== cur.we || o_mem_addr !== cur.addr ||
              o_mem_wdata !== cur.wdata) cur.stable = 1'b0;
        end else if (o_mem_req === 1'b1) begin
          busy = 1'b1;
          cnt = 1;
          cur.we = o_mem_we;
          cur.addr = o_mem_addr;
          cur.wdata = o_mem_wdata;
          cur.lat = rand_lat ? int'($urandom_range(1, 4)) : ack_lat;
          cur.stable = 1'b1;
        end
        if (busy && auto_ack && cnt == cur.lat) begin
          i_mem_ack = 1'b1;
          if (cur.we) begin
            mem_arr[cur.addr] = cur.wdata;
            i_mem_rdata = $urandom;
          end else begin
            i_mem_rdata = mem_read(cur.addr);
          end
          acc_q.push_back(cur);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input bit use_if, input bit use_dm, input logic [31:0] ia,
                           input logic [31:0] da, input logic [31:0] dwd, input bit dwe,
                           output logic [31:0] if_data, output logic [31:0] dm_data,
                           output int if_cyc, output int dm_cyc, output int if_vn,
                           output int dm_vn, output int stall_bad, output bit timeout);
    bit if_done, dm_done;
    int cyc;
    if_data = '0; dm_data = '0; if_cyc = -1; dm_cyc = -1;
    if_vn = 0; dm_vn = 0; stall_bad = 0; cyc = 0;
    if_done = !use_if;
    dm_done = !use_dm;
    @(posedge clk); #1;
    i_if_req = use_if; i_if_addr = ia;
    i_dm_req = use_dm; i_dm_addr = da; i_dm_wdata = dwd; i_dm_we = dwe;
    while (!(if_done && dm_done) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_if_stall !== (i_if_req && !o_if_valid)) stall_bad++;
      if (o_if_valid === 1'b1) begin
        if_vn++;
        if (!if_done) begin if_data = o_if_rdata; if_cyc = cyc; if_done = 1'b1; end
      end
      if (o_dm_valid === 1'b1) begin
        dm_vn++;
        if (!dm_done) begin dm_data = o_dm_rdata; dm_cyc = cyc; dm_done = 1'b1; end
      end
      @(posedge clk); #1;
      if (if_done) i_if_req = 1'b0;
      if (dm_done) i_dm_req = 1'b0;
    end
    timeout = !(if_done && dm_done);
    i_if_req = 1'b0;
    i_dm_req = 1'b0;
    @(negedge clk);
    if (o_if_valid === 1'b1) if_vn++;
    if (o_dm_valid === 1'b1) dm_vn++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++; if (o_mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
    n_cmp++; if (o_mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", o_mem_we); end
    n_cmp++; if (o_mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
    n_cmp++; if (o_mem_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", o_mem_wdata); end
    n_cmp++; if (o_if_valid !== 1'b0 || o_dm_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got if=%b dm=%b want 0 0", o_if_valid, o_dm_valid); end
    n_cmp++; if (o_if_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_if_rdata: got %h want 0", o_if_rdata); end
    n_cmp++; if (o_dm_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_dm_rdata: got %h want 0", o_dm_rdata); end
    n_cmp++; if (o_if_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", o_if_stall); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_fetch();
    logic [31:0] ifd, dmd;
    int ic, dc, iv, dv, sb;
    bit to;
    mem_arr[32'h40] = 32'h2008_0005;
    ref_mem[32'h40] = 32'h2008_0005;
    rand_lat = 1'b0; ack_lat = 1; acc_q.delete();
    do_access(1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, ifd, dmd, ic, dc, iv, dv, sb, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL fetch_timeout: got timeout want completion"); end
    n_cmp++;
    if (acc_q.size() != 1) begin n_bad++; $display("FAIL fetch_access_count: got %0d want 1", acc_q.size()); end
    else if (acc_q[0].addr !== 32'h40 || acc_q[0].we !== 1'b0 || !acc_q[0].stable) begin
      n_bad++; $display("FAIL fetch_mem_ops: got addr %h we %b stable %b want 40 0 1", acc_q[0].addr, acc_q[0].we, acc_q[0].stable);
    end
    n_cmp++; if (ifd !== 32'h2008_0005) begin n_bad++; $display("FAIL fetch_rdata: got %h want 20080005", ifd); end
    n_cmp++; if (ic !== 3) begin n_bad++; $display("FAIL fetch_latency: got cycle %0d want 3", ic); end
    n_cmp++; if (iv !== 1 || dv !== 0) begin n_bad++; $display("FAIL fetch_pulses: got if %0d dm %0d want 1 0", iv, dv); end
    n_cmp++; if (sb !== 0) begin n_bad++; $display("FAIL fetch_stall: got %0d bad cycles want 0", sb); end
    m_if_rdata = 32'h2008_0005;
    m_ptr_dm = 1'b1;
  endtask

  task automatic test_store();
    logic [31:0] ifd, dmd;
    int ic, dc, iv, dv, sb;
    bit to;
    rand_lat = 1'b0; ack_lat = 1; acc_q.delete();
    do_access(1'b0, 1'b1, 32'h0, 32'h300, 32'h0, 1'b0, ifd, dmd, ic, dc, iv, dv, sb, to);
    m_dm_rdata = ref_read(32'h300);
    m_ptr_dm = 1'b0;
    n_cmp++; if (to || dmd !== m_dm_rdata) begin n_bad++; $display("FAIL preload_load: got %h to=%b want %h", dmd, to, m_dm_rdata); end
    ack_lat = 3; acc_q.delete();
    do_access(1'b0, 1'b1, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b1, ifd, dmd, ic, dc, iv, dv, sb, to);
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    n_cmp++;
    if (acc_q.size() != 1) begin n_bad++; $display("FAIL store_access_count: got %0d want 1", acc_q.size()); end
    else if (acc_q[0].we !== 1'b1 || acc_q[0].addr !== 32'h100 || acc_q[0].wdata !== 32'hDEAD_BEEF || !acc_q[0].stable) begin
      n_bad++; $display("FAIL store_mem_ops: got we %b addr %h wdata %h stable %b want 1 100 deadbeef 1",
                        acc_q[0].we, acc_q[0].addr, acc_q[0].wdata, acc_q[0].stable);
    end
    n_cmp++; if (dc !== 5 || dv !== 1 || iv !== 0) begin n_bad++; $display("FAIL store_valid: got cycle %0d pulses dm %0d if %0d want 5 1 0", dc, dv, iv); end
    n_cmp++; if (dmd !== m_dm_rdata) begin n_bad++; $display("FAIL store_rdata_hold: got %h want %h", dmd, m_dm_rdata); end
    ack_lat = 2; acc_q.delete();
    do_access(1'b0, 1'b1, 32'h0, 32'h100, 32'h0, 1'b0, ifd, dmd, ic, dc, iv, dv, sb, to);
    m_dm_rdata = ref_read(32'h100);
    n_cmp++; if (dmd !== 32'hDEAD_BEEF || dc !== 4) begin n_bad++; $display("FAIL store_readback: got %h at %0d want deadbeef at 4", dmd, dc); end
  endtask

  task automatic test_arbitration();
    logic [31:0] ifd, dmd;
    int ic, dc, iv, dv, sb, t0, t1;
    bit to, dm_first;
    rand_lat = 1'b0; ack_lat = 2;
    for (int p = 0; p < 3; p++) begin
      dm_first = model_dm_first();
      acc_q.delete();
      do_access(1'b1, 1'b1, 32'h40, 32'h200, 32'h0, 1'b0, ifd, dmd, ic, dc, iv, dv, sb, to);
      m_if_rdata = ref_read(32'h40);
      m_dm_rdata = ref_read(32'h200);
      n_cmp++;
      if (acc_q.size() != 2) begin n_bad++; $display("FAIL arb_count pair %0d: got %0d want 2", p, acc_q.size()); end
      else begin
        if (acc_q[0].addr !== (dm_first ? 32'h200 : 32'h40) || acc_q[1].addr !== (dm_first ? 32'h40 : 32'h200)) begin
          n_bad++; $display("FAIL arb_order pair %0d: got %h then %h want dm_first=%b", p, acc_q[0].addr, acc_q[1].addr, dm_first);
        end
        t0 = 2 + acc_q[0].lat;
        t1 = t0 + 2 + acc_q[1].lat;
        n_cmp++;
        if ((dm_first ? dc : ic) !== t0 || (dm_first ? ic : dc) !== t1) begin
          n_bad++; $display("FAIL arb_latency pair %0d: got dm %0d if %0d want first %0d second %0d", p, dc, ic, t0, t1);
        end
      end
      n_cmp++; if (ifd !== m_if_rdata || dmd !== m_dm_rdata) begin n_bad++; $display("FAIL arb_rdata pair %0d: got if %h dm %h want %h %h", p, ifd, dmd, m_if_rdata, m_dm_rdata); end
      n_cmp++; if (to || iv !== 1 || dv !== 1 || sb !== 0) begin n_bad++; $display("FAIL arb_pulses pair %0d: got to %b if %0d dm %0d stall %0d want 0 1 1 0", p, to, iv, dv, sb); end
      m_ptr_dm = dm_first;
    end
  endtask

  task automatic test_drop();
    int n, ifv, reqs;
    bit got;
    logic [31:0] dmd;
    rand_lat = 1'b0; ack_lat = 4; acc_q.delete();
    n = 0; ifv = 0; reqs = 0; got = 1'b0; dmd = '0;
    @(posedge clk); #1;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h300;
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h80;
    @(negedge clk);
    n_cmp++; if (o_if_stall !== 1'b1) begin n_bad++; $display("FAIL drop_stall: got %b want 1", o_if_stall); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_if_req = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (o_if_valid === 1'b1) ifv++;
      if (o_dm_valid === 1'b1) begin got = 1'b1; dmd = o_dm_rdata; end
    end
    @(posedge clk); #1;
    i_dm_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (o_if_valid === 1'b1) ifv++;
      if (o_mem_req === 1'b1) reqs++;
    end
    m_dm_rdata = ref_read(32'h300);
    m_ptr_dm = 1'b0;
    n_cmp++; if (!got || dmd !== m_dm_rdata) begin n_bad++; $display("FAIL drop_dm_load: got %h done %b want %h", dmd, got, m_dm_rdata); end
    n_cmp++; if (ifv !== 0 || reqs !== 0) begin n_bad++; $display("FAIL drop_no_fetch: got if_valid %0d mem_req cycles %0d want 0 0", ifv, reqs); end
    n_cmp++; if (acc_q.size() != 1) begin n_bad++; $display("FAIL drop_access_count: got %0d want 1", acc_q.size()); end
  endtask

  task automatic test_spurious_ack();
    logic [31:0] ifd, dmd;
    int ic, dc, iv, dv, sb;
    bit to;
    rand_lat = 1'b0; ack_lat = 1; acc_q.delete();
    do_access(1'b0, 1'b1, 32'h0, 32'h3C, 32'h1357_9BDF, 1'b1, ifd, dmd, ic, dc, iv, dv, sb, to);
    ref_mem[32'h3C] = 32'h1357_9BDF;
    m_ptr_dm = 1'b0;
    n_cmp++; if (to || dmd !== m_dm_rdata) begin n_bad++; $display("FAIL spur_setup_store: got %h to=%b want %h", dmd, to, m_dm_rdata); end
    @(posedge clk); #1;
    spur_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_mem_req !== 1'b0 || o_if_valid !== 1'b0 || o_dm_valid !== 1'b0 || dbg_state !== 2'd0 || o_if_stall !== 1'b0) begin
        n_bad++; $display("FAIL spur_ctrl cyc %0d: got req %b ifv %b dmv %b st %0d stall %b want 0 0 0 0 0",
                          k, o_mem_req, o_if_valid, o_dm_valid, dbg_state, o_if_stall);
      end
      n_cmp++;
      if (o_if_rdata !== m_if_rdata || o_dm_rdata !== m_dm_rdata || o_mem_addr !== 32'h3C ||
          o_mem_we !== 1'b1 || o_mem_wdata !== 32'h1357_9BDF) begin
        n_bad++; $display("FAIL spur_data cyc %0d: got ifr %h dmr %h addr %h we %b wd %h want %h %h 3c 1 13579bdf",
                          k, o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_we, o_mem_wdata, m_if_rdata, m_dm_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    auto_ack = 1'b0; acc_q.delete();
    @(posedge clk); #1;
    i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h200;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd2 || o_mem_req !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy: got st %0d req %b want 2 1", dbg_state, o_mem_req); end
    @(posedge clk); #1;
    i_rst_n = 1'b0; i_dm_req = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd0 || o_mem_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid_after: got st %0d req %b want 0 0", dbg_state, o_mem_req); end
    @(posedge clk); #1;
    spur_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (o_dm_valid !== 1'b0 || o_mem_req !== 1'b0 || dbg_state !== 2'd0 || o_dm_rdata !== m_dm_rdata || o_if_rdata !== m_if_rdata) begin
        n_bad++; $display("FAIL rst_mid_late_ack cyc %0d: got dmv %b req %b st %0d dmr %h ifr %h want 0 0 0 %h %h",
                          k, o_dm_valid, o_mem_req, dbg_state, o_dm_rdata, o_if_rdata, m_dm_rdata, m_if_rdata);
      end
    end
    auto_ack = 1'b1;
  endtask

  task automatic test_random(input int n_groups);
    logic [31:0] ifd, dmd, ia, da, dwd, ea;
    int ic, dc, iv, dv, sb, kind, n_acc, t, exp_ic, exp_dc;
    bit to, use_if, use_dm, dwe, dm_first, is_dm;
    acc_t a;
    rand_lat = 1'b1;
    for (int g = 0; g < n_groups; g++) begin
      kind = int'($urandom_range(0, 2));
      use_if = (kind != 1);
      use_dm = (kind != 0);
      ia = 32'($urandom_range(0, 15)) * 32'd4;
      da = 32'($urandom_range(0, 15)) * 32'd4;
      dwd = $urandom;
      dwe = 1'($urandom_range(0, 1));
      dm_first = use_dm && (!use_if || model_dm_first());
      n_acc = int'(use_if) + int'(use_dm);
      exp_q.delete();
      if (dm_first) exp_q.push_back(da);
      if (use_if) exp_q.push_back(ia);
      if (use_dm && !dm_first) exp_q.push_back(da);
      acc_q.delete();
      do_access(use_if, use_dm, ia, da, dwd, dwe, ifd, dmd, ic, dc, iv, dv, sb, to);
      n_cmp++;
      if (to || acc_q.size() != n_acc) begin
        n_bad++; $display("FAIL rand_count g%0d: got %0d accesses to=%b want %0d", g, acc_q.size(), to, n_acc);
      end else begin
        t = 0; exp_ic = -1; exp_dc = -1;
        for (int k = 0; k < n_acc; k++) begin
          is_dm = (k == 0) ? dm_first : !dm_first;
          a = acc_q[k];
          ea = exp_q.pop_front();
          t = t + 2 + a.lat;
          n_cmp++;
          if (a.addr !== ea || a.we !== (is_dm ? dwe : 1'b0) || (is_dm && a.wdata !== dwd) || !a.stable) begin
            n_bad++; $display("FAIL rand_access g%0d k%0d: got addr %h we %b wd %h stable %b want %h %b %h 1",
                              g, k, a.addr, a.we, a.wdata, a.stable, ea, is_dm ? dwe : 1'b0, dwd);
          end
          if (is_dm) begin
            if (dwe) ref_mem[da] = dwd;
            else m_dm_rdata = ref_read(da);
            exp_dc = t;
            m_ptr_dm = 1'b0;
          end else begin
            m_if_rdata = ref_read(ia);
            exp_ic = t;
            m_ptr_dm = 1'b1;
          end
        end
        if (use_dm) begin
          n_cmp++; if (dmd !== m_dm_rdata || dc !== exp_dc) begin n_bad++; $display("FAIL rand_dm g%0d: got %h at %0d want %h at %0d", g, dmd, dc, m_dm_rdata, exp_dc); end
        end
        if (use_if) begin
          n_cmp++; if (ifd !== m_if_rdata || ic !== exp_ic) begin n_bad++; $display("FAIL rand_if g%0d: got %h at %0d want %h at %0d", g, ifd, ic, m_if_rdata, exp_ic); end
        end
      end
      n_cmp++;
      if (iv !== int'(use_if) || dv !== int'(use_dm) || sb !== 0) begin
        n_bad++; $display("FAIL rand_pulses g%0d: got if %0d dm %0d stall %0d want %0d %0d 0", g, iv, dv, sb, use_if, use_dm);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rand_lat = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_arbitration();
    test_drop();
    test_spurious_ack();
    test_reset_mid_access();
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_if_req  input  1  fetch read request; held until o_if_valid.
REQ-006 SHALL have port i_if_addr  input  ADDR_W  fetch address (current PC).
REQ-007 SHALL have port o_if_valid  output  1  one-cycle pulse: o_if_rdata holds the fetched instruction.
REQ-008 SHALL have port o_if_rdata  output  DATA_W  fetched instruction word.
REQ-009 SHALL have port o_if_stall  output  1  freeze PC update; equals i_if_req AND NOT o_if_valid.
REQ-010 SHALL have port i_dm_req  input  1  data request; held until o_dm_valid.
REQ-011 SHALL have port i_dm_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port i_dm_addr  input  ADDR_W  data address.
REQ-013 SHALL have port i_dm_wdata  input  DATA_W  store data.
REQ-014 SHALL have port o_dm_valid  output  1  one-cycle pulse: data access complete.
REQ-015 SHALL have port o_dm_rdata  output  DATA_W  load data.
REQ-016 SHALL have port o_mem_req  output  1  request to the shared single-port memory.
REQ-017 SHALL have port o_mem_we  output  1  memory write enable.
REQ-018 SHALL have port o_mem_addr  output  ADDR_W  latched memory address.
REQ-019 SHALL have port o_mem_wdata  output  DATA_W  latched write data.
REQ-020 SHALL have port i_mem_rdata  input  DATA_W  memory read data, valid with i_mem_ack.
REQ-021 SHALL have port i_mem_ack  input  1  one-cycle pulse: access complete, arbitrary latency >= 1 cycle.

Function
REQ-022 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY, RESP.
REQ-023 In IDLE with any request at a rising edge, SHALL latch the winner's addr/we/wdata into o_mem_* and enter IF_BUSY or DM_BUSY; o_mem_req high from the next cycle.
REQ-024 Fetch accesses SHALL drive o_mem_we = 0.
REQ-025 Arbitration when both requests present in IDLE SHALL follow REQ-040/REQ-041.
REQ-026 In *_BUSY, o_mem_req and o_mem_addr/we/wdata SHALL stay constant until i_mem_ack.
REQ-027 On i_mem_ack in *_BUSY, SHALL register i_mem_rdata into the owner's rdata output (loads and fetches only), deassert o_mem_req, and enter RESP.
REQ-028 In RESP, SHALL pulse exactly the owner's o_*_valid for one cycle, then return to IDLE.
REQ-029 Minimum latency: request at edge N -> o_mem_req at N+1 -> ack at N+1 earliest -> valid in cycle N+2.
REQ-030 o_dm_rdata SHALL hold its previous value across stores; o_if_rdata and o_dm_rdata SHALL hold between accesses.
REQ-031 i_mem_ack in IDLE or RESP SHALL be ignored (no state or output change).
REQ-032 A request deasserted while not granted SHALL be dropped without memory access.
REQ-033 Back-to-back: a request pending in the cycle after RESP SHALL be granted at that edge; no bubble beyond RESP.

Reset
REQ-034 With i_rst_n low at a rising edge, SHALL enter IDLE regardless of state, including mid-access.
REQ-035 Reset values: o_mem_req 0, o_mem_we 0, o_mem_addr 0, o_mem_wdata 0, o_if_valid 0, o_dm_valid 0, o_if_rdata 0, o_dm_rdata 0, priority pointer = data.
REQ-036 An ack arriving after reset for an aborted access SHALL be ignored per REQ-031.

Configuration
REQ-037 Macro MEM_ARB_RR_EN SHALL select the arbitration policy.
REQ-038 Absent: fixed priority, data wins over fetch.
REQ-039 Defined: round-robin; one-bit pointer flips to the other requester after each grant.
REQ-040 Without MEM_ARB_RR_EN, concurrent requests SHALL grant DM, then IF if still pending.
REQ-041 With MEM_ARB_RR_EN, concurrent requests SHALL grant the pointer's requester; first concurrent grant after reset goes to DM.

Verification
REQ-042 Fetch only, addr 0x0000_0040, ack 1 cycle after o_mem_req with rdata 0x2008_0005 -> o_mem_addr 0x40, we 0, o_if_valid one cycle with o_if_rdata 0x2008_0005, o_if_stall low in that cycle.
REQ-043 Store addr 0x100 wdata 0xDEAD_BEEF, ack after 3 cycles -> o_mem_we 1, o_mem_wdata 0xDEAD_BEEF stable 3 cycles, o_dm_valid pulse, o_dm_rdata unchanged.
REQ-044 IF and DM (load 0x200) asserted same edge, macro absent -> DM served first, IF second; three alternating concurrent pairs under MEM_ARB_RR_EN -> grants DM, IF, DM, IF, DM, IF.
REQ-045 i_rst_n low for one edge during DM_BUSY, ack arrives 2 cycles later -> o_mem_req 0 after reset edge, no o_dm_valid, state IDLE.
REQ-046 Spurious i_mem_ack in IDLE with no requests -> all outputs unchanged.
